mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-ported unified RAM: instruction fetch vs. load/store.
// Data normally wins ties. A fetch is forced through after STARVE_MAX consecutive data grants.
module mem_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // state  | meaning
  // IDLE   | arbitrate; a grant drives the RAM in this same cycle
  // WAIT_I | fetch response cycle, RAM data routed to if_rdata
  // WAIT_D | data response cycle, RAM data routed to d_rdata on loads
  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        load_q, load_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      load_q       <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      load_q       <= load_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    load_d       = load_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    if_rvalid    = 1'b0;
    d_done       = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if_rdata     = if_rdata_q;
    d_rdata      = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        // Grants are combinational, so gate them while reset is held.
        if (!rst) begin
          if (if_req && (starve_cnt_q == STARVE_LIM || !d_req)) begin
            if_gnt       = 1'b1;
            mem_en       = 1'b1;
            mem_addr     = if_addr;
            starve_cnt_d = '0;
            state_d      = WAIT_I;
          end else if (d_req) begin
            d_gnt     = 1'b1;
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            load_d    = !d_we;
            state_d   = WAIT_D;
            if (!if_req)
              starve_cnt_d = '0;
            else if (starve_cnt_q < STARVE_LIM)
              starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end
      end
      WAIT_I: begin
        if_rvalid  = 1'b1;
        if_rdata   = mem_rdata[31:0];
        if_rdata_d = mem_rdata[31:0];
        state_d    = IDLE;
      end
      WAIT_D: begin
        d_done  = 1'b1;
        if (load_q) begin
          d_rdata   = mem_rdata;
          d_rdata_d = mem_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int AW = 13;
  localparam int DW = 64;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic          if_gnt, if_rvalid, d_gnt, d_done, mem_en, mem_we;
  logic [31:0]   if_rdata;
  logic [DW-1:0] d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  // reference model: pending response kind (0 none, 1 fetch, 2 load, 3 store)
  int            m_pend;
  int            m_starve;
  logic [31:0]   m_if;
  logic [DW-1:0] m_d;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; if_addr = 13'h0AA; d_addr = 13'h055; d_wdata = 64'h1234;
    @(negedge clk);
    checks++;
    if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_done} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000000", {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_done});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errors++; $display("FAIL reset_mem got addr=%h wdata=%h exp 0", mem_addr, mem_wdata);
    end
    checks++;
    if (if_rdata !== '0 || d_rdata !== '0) begin
      errors++; $display("FAIL reset_rdata got if=%h d=%h exp 0", if_rdata, d_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 13'h055) begin
      errors++; $display("FAIL first_arb got gnt=%b en=%b addr=%h exp 1 1 055", d_gnt, mem_en, mem_addr);
    end
    @(posedge clk); #1 d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (d_done !== 1'b1) begin errors++; $display("FAIL first_done got %b exp 1", d_done); end
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_only();
    do_reset();
    if_req = 1'b1; if_addr = 13'h010;
    @(negedge clk);
    checks++;
    if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 13'h010 || mem_wdata !== '0) begin
      errors++; $display("FAIL fetch_gnt got gnt/en/we=%b addr=%h exp 1010 010", {if_gnt, d_gnt, mem_en, mem_we}, mem_addr);
    end
    @(posedge clk); #1;
    if_req = 1'b0; mem_rdata = 64'hABCD0000_00000013;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h00000013 || mem_en !== 1'b0) begin
      errors++; $display("FAIL fetch_rvalid got rv=%b data=%h en=%b exp 1 00000013 0", if_rvalid, if_rdata, mem_en);
    end
    @(posedge clk); #1 mem_rdata = 64'h5555AAAA_5555AAAA;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'h00000013) begin
      errors++; $display("FAIL fetch_hold got rv=%b data=%h exp 0 00000013", if_rvalid, if_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_then_fetch();
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 13'h200; if_req = 1'b1; if_addr = 13'h044;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 13'h200) begin
      errors++; $display("FAIL load_gnt got d=%b i=%b we=%b addr=%h exp 1 0 0 200", d_gnt, if_gnt, mem_we, mem_addr);
    end
    @(posedge clk); #1;
    d_req = 1'b0; mem_rdata = 64'h1122334455667788;
    @(negedge clk);
    checks++;
    if (d_done !== 1'b1 || d_rdata !== 64'h1122334455667788 || if_gnt !== 1'b0) begin
      errors++; $display("FAIL load_done got done=%b data=%h ignt=%b exp 1 1122334455667788 0", d_done, d_rdata, if_gnt);
    end
    @(posedge clk); #1 mem_rdata = 64'h0F0F0F0F_0F0F0F0F;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1 || mem_addr !== 13'h044 || d_rdata !== 64'h1122334455667788 || d_done !== 1'b0) begin
      errors++; $display("FAIL load_fetch got ignt=%b addr=%h drd=%h done=%b exp 1 044 1122334455667788 0",
                         if_gnt, mem_addr, d_rdata, d_done);
    end
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h0F0F0F0F) begin
      errors++; $display("FAIL load_fetch_rv got rv=%b data=%h exp 1 0f0f0f0f", if_rvalid, if_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 13'h100; d_wdata = 64'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 13'h100 || mem_wdata !== 64'hDEADBEEF) begin
      errors++; $display("FAIL store_gnt got gnt=%b en=%b we=%b addr=%h wd=%h exp 1 1 1 100 deadbeef",
                         d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0; mem_rdata = 64'hCAFEF00D_CAFEF00D;
    @(negedge clk);
    checks++;
    if (d_done !== 1'b1 || d_rdata !== 64'h1122334455667788) begin
      errors++; $display("FAIL store_done got done=%b data=%h exp 1 1122334455667788", d_done, d_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    do_reset();
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 13'h004; d_addr = 13'h008;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k % 2 == 1) exp_g = 2'b00;
      else if ((k / 2) % 5 == 4) exp_g = 2'b10;
      else exp_g = 2'b01;
      checks++;
      if ({if_gnt, d_gnt} !== exp_g) begin
        errors++; $display("FAIL contention cyc=%0d got {i,d}=%b exp %b", k, {if_gnt, d_gnt}, exp_g);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    int nd;
    bit found;
    do_reset();
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 13'h002; d_addr = 13'h001;
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) begin @(posedge clk); #1; end
    #2;
    checks++;
    if (d_done !== 1'b1) begin errors++; $display("FAIL pre_rst_done got %b exp 1", d_done); end
    rst = 1'b1;
    #1;
    checks++;
    if ({d_done, if_rvalid, mem_en, d_gnt, if_gnt} !== 5'b0 || d_rdata !== '0) begin
      errors++; $display("FAIL rst_async got ctrl=%b drd=%h exp 00000 0", {d_done, if_rvalid, mem_en, d_gnt, if_gnt}, d_rdata);
    end
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (d_done !== 1'b0 || if_rvalid !== 1'b0) begin
      errors++; $display("FAIL rst_discard got done=%b rv=%b exp 0 0", d_done, if_rvalid);
    end
    @(posedge clk); #1;
    if_req = 1'b1; d_req = 1'b1;
    nd = 0; found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (d_gnt) nd++;
      if (if_gnt) found = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (!found || nd != SM) begin
      errors++; $display("FAIL rst_starve got found=%0d data_grants=%0d exp 1 %0d", found, nd, SM);
    end
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int pick;
    bit last_ig, last_dg;
    logic [5:0] e_ctrl;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_drd;
    logic [31:0] e_ird;
    do_reset();
    m_pend = 0; m_starve = 0; m_if = '0; m_d = '0;
    last_ig = 1'b0; last_dg = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (if_req && !last_ig) begin
        if ($urandom_range(9) == 0) if_req = 1'b0;
      end else begin
        if_req = 1'($urandom_range(1)); if_addr = AW'($urandom);
      end
      if (d_req && !last_dg) begin
        if ($urandom_range(9) == 0) d_req = 1'b0;
      end else begin
        d_req = 1'($urandom_range(1)); d_we = 1'($urandom_range(1));
        d_addr = AW'($urandom); d_wdata = {$urandom, $urandom};
      end
      mem_rdata = {$urandom, $urandom};
      @(negedge clk);
      pick = 0;
      if (m_pend == 0) begin
        if (if_req && m_starve == SM) pick = 1;
        else if (d_req) pick = 2;
        else if (if_req) pick = 1;
      end
      e_addr = (pick == 1) ? if_addr : (pick == 2) ? d_addr : '0;
      e_wd   = (pick == 2) ? d_wdata : '0;
      e_ird  = (m_pend == 1) ? mem_rdata[31:0] : m_if;
      e_drd  = (m_pend == 2) ? mem_rdata : m_d;
      // {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_done}
      e_ctrl = {pick == 1, pick == 2, pick != 0, pick == 2 && d_we, m_pend == 1, m_pend >= 2};
      checks++;
      if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_done} !== e_ctrl) begin
        errors++; $display("FAIL rand_ctrl n=%0d got %b exp %b", n, {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_done}, e_ctrl);
      end
      checks++;
      if (mem_addr !== e_addr || mem_wdata !== e_wd) begin
        errors++; $display("FAIL rand_mem n=%0d got %h/%h exp %h/%h", n, mem_addr, mem_wdata, e_addr, e_wd);
      end
      checks++;
      if (if_rdata !== e_ird || d_rdata !== e_drd) begin
        errors++; $display("FAIL rand_rdata n=%0d got %h/%h exp %h/%h", n, if_rdata, d_rdata, e_ird, e_drd);
      end
      checks++;
      if ((if_gnt && d_gnt) || (if_rvalid && d_done)) begin
        errors++; $display("FAIL rand_excl n=%0d got gnt=%b%b resp=%b%b exp at most one", n, if_gnt, d_gnt, if_rvalid, d_done);
      end
      if (m_pend == 1) m_if = mem_rdata[31:0];
      if (m_pend == 2) m_d = mem_rdata;
      if (m_pend != 0) m_pend = 0;
      else if (pick == 1) begin m_pend = 1; m_starve = 0; end
      else if (pick == 2) begin
        m_pend = d_we ? 3 : 2;
        m_starve = if_req ? ((m_starve + 1 > SM) ? SM : m_starve + 1) : 0;
      end
      last_ig = (pick == 1);
      last_dg = (pick == 2);
      @(posedge clk); #1;
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_load_then_fetch();
    test_store();
    test_contention();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
